hazard_forward_unit: RTL and testbench

Parametrised successor to the pipeline's fixed two-source forwarding unit. It combines N-source priority operand forwarding for the Execute stage with a registered load-use hazard controller. The controller stalls Fetch and the FD buffer and injects bubbles into the DE buffer for a configurable number of cycles. A branch-flush input aborts a stall, and a saturating counter records stall cycles. The block sits between the DE buffer outputs and the Execute stage, clocked by the same clock as the pipeline buffers.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_forward_unit_fwd_mux.sv | 27 ++
 rtl/hazard_forward_unit.sv | 121 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard controller and operand forwarding.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

  // Control word loaded into the DE buffer when a bubble is injected.
  localparam logic [12:0] NOP_CTRL = 13'b0;

  // Forwarding sources are ordered youngest first: index 0 is EM, the highest index is MW.
  localparam int SRC_EM = 0;

  localparam int REM_W = 4;

endpackage

// File: rtl/hazard_forward_unit_fwd_mux.sv
// NSRC-way priority operand matcher: the youngest matching source wins, else the fall-back operand.
module fwd_mux
  import hazard_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3,
  parameter int NSRC   = 2
) (
  input  logic [RA_W-1:0]        rs_i,
  input  logic [DATA_W-1:0]      fallback_i,
  input  logic [NSRC-1:0]        we_i,
  input  logic [NSRC*RA_W-1:0]   wa_i,
  input  logic [NSRC*DATA_W-1:0] data_i,
  output logic [DATA_W-1:0]      data_o
);

  // Scan oldest to youngest so a younger match overrides any older one.
  always_comb begin
    data_o = fallback_i;
    for (int i = NSRC - 1; i >= SRC_EM; i--) begin
      if (we_i[i] && (wa_i[i*RA_W +: RA_W] == rs_i)) begin
        data_o = data_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Execute-stage operand forwarding plus a load-use stall/bubble controller with a saturating stall counter.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int RA_W     = 3,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RA_W-1:0]          ex_rs1,
  input  logic [RA_W-1:0]          ex_rs2,
  input  logic [DATA_W-1:0]        ex_rd1,
  input  logic [DATA_W-1:0]        ex_rd2,
  input  logic [NSRC-1:0]          fwd_we,
  input  logic [NSRC*RA_W-1:0]     fwd_wa,
  input  logic [NSRC*DATA_W-1:0]   fwd_data,
  input  logic                     ex_valid,
  input  logic                     ex_mem_read,
  input  logic [RA_W-1:0]          ex_rd,
  input  logic                     id_valid,
  input  logic                     id_uses_rs2,
  input  logic [RA_W-1:0]          id_rs1,
  input  logic [RA_W-1:0]          id_rs2,
  input  logic                     flush,
  output logic [DATA_W-1:0]        fu_data1,
  output logic [DATA_W-1:0]        fu_data2,
  output logic                     stall,
  output logic                     bubble,
  output logic [CNT_W-1:0]         stall_count
);

  localparam logic [REM_W-1:0] HOLD_INIT = REM_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  hz_state_e         state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit;
  logic              stall_w;

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .NSRC(NSRC)) u_fwd1 (
    .rs_i       (ex_rs1),
    .fallback_i (ex_rd1),
    .we_i       (fwd_we),
    .wa_i       (fwd_wa),
    .data_i     (fwd_data),
    .data_o     (fu_data1)
  );

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .NSRC(NSRC)) u_fwd2 (
    .rs_i       (ex_rs2),
    .fallback_i (ex_rd2),
    .we_i       (fwd_we),
    .wa_i       (fwd_wa),
    .data_i     (fwd_data),
    .data_o     (fu_data2)
  );

  assign hit = ex_valid & ex_mem_read & id_valid &
               ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  // A flush kills the decode instruction, so it always cancels the stall for that cycle.
  always_comb begin
    stall_w = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    stall_w = hit & ~flush;
        HOLD:    stall_w = ~flush;
        default: stall_w = 1'b0;
      endcase
    end
  end

  assign stall  = stall_w;
  assign bubble = stall_w;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (hit && !flush && (LOAD_LAT > 1)) begin
          state_d = HOLD;
          rem_d   = HOLD_INIT;
        end
      end
      HOLD: begin
        if (flush || (rem_q == REM_W'(1))) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - REM_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  assign cnt_d = (stall_w && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: three hazard_forward_unit configurations driven in parallel against a behavioural model.
module tb_hazard_forward_unit;

  localparam int DATA_W = 16;
  localparam int RA_W   = 3;
  localparam int NSRC   = 2;
  localparam int NDUT   = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [RA_W-1:0]        ex_rs1, ex_rs2, ex_rd, id_rs1, id_rs2;
  logic [DATA_W-1:0]      ex_rd1, ex_rd2;
  logic [NSRC-1:0]        fwd_we;
  logic [NSRC*RA_W-1:0]   fwd_wa;
  logic [NSRC*DATA_W-1:0] fwd_data;
  logic                   ex_valid, ex_mem_read, id_valid, id_uses_rs2, flush;

  logic [NDUT-1:0][DATA_W-1:0] fu1Act, fu2Act;
  logic [NDUT-1:0]             stallAct, bubbleAct;
  logic [15:0]                 cnt0, cnt1;
  logic [1:0]                  cnt2;
  logic [NDUT-1:0][15:0]       cntAct;

  int nChecks = 0;
  int nFail   = 0;

  int     remM[NDUT];
  longint cntM[NDUT];

  always #5 clk = ~clk;

  // Instance 0: LOAD_LAT=1; instance 1: LOAD_LAT=3; instance 2: LOAD_LAT=3 with a 2-bit counter.
  hazard_forward_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .NSRC(NSRC), .LOAD_LAT(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .fwd_we(fwd_we), .fwd_wa(fwd_wa), .fwd_data(fwd_data), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_valid(id_valid), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .flush(flush), .fu_data1(fu1Act[0]), .fu_data2(fu2Act[0]),
    .stall(stallAct[0]), .bubble(bubbleAct[0]), .stall_count(cnt0));

  hazard_forward_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .NSRC(NSRC), .LOAD_LAT(3), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .fwd_we(fwd_we), .fwd_wa(fwd_wa), .fwd_data(fwd_data), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_valid(id_valid), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .flush(flush), .fu_data1(fu1Act[1]), .fu_data2(fu2Act[1]),
    .stall(stallAct[1]), .bubble(bubbleAct[1]), .stall_count(cnt1));

  hazard_forward_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .NSRC(NSRC), .LOAD_LAT(3), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .fwd_we(fwd_we), .fwd_wa(fwd_wa), .fwd_data(fwd_data), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_valid(id_valid), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .flush(flush), .fu_data1(fu1Act[2]), .fu_data2(fu2Act[2]),
    .stall(stallAct[2]), .bubble(bubbleAct[2]), .stall_count(cnt2));

  assign cntAct[0] = cnt0;
  assign cntAct[1] = cnt1;
  assign cntAct[2] = {14'b0, cnt2};

  function automatic int latOf(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic longint maxOf(int k);
    return (k == 2) ? 64'd3 : 64'd65535;
  endfunction

  function automatic logic modelHit();
    return ex_valid && ex_mem_read && id_valid &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  endfunction

  // remM[k] counts stall cycles still owed after the current one for instance k.
  function automatic logic expStall(int k);
    if (reset) return 1'b0;
    if (remM[k] > 0) return !flush;
    return modelHit() && !flush;
  endfunction

  function automatic logic [DATA_W-1:0] expFwd(logic [RA_W-1:0] rs, logic [DATA_W-1:0] fb);
    for (int i = 0; i < NSRC; i++) begin
      if (fwd_we[i] && (fwd_wa[i*RA_W +: RA_W] == rs)) return fwd_data[i*DATA_W +: DATA_W];
    end
    return fb;
  endfunction

  task automatic checkOutput(string name, int k, longint act, longint exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s dut%0d at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NDUT; k++) begin
        remM[k] = 0;
        cntM[k] = 0;
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        logic s;
        s = expStall(k);
        if (s && (cntM[k] < maxOf(k))) cntM[k]++;
        if (remM[k] > 0) remM[k] = flush ? 0 : remM[k] - 1;
        else if (s) remM[k] = latOf(k) - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("stall", k, stallAct[k], expStall(k));
      checkOutput("bubble", k, bubbleAct[k], expStall(k));
      checkOutput("stall_count", k, cntAct[k], cntM[k]);
      checkOutput("fu_data1", k, fu1Act[k], expFwd(ex_rs1, ex_rd1));
      checkOutput("fu_data2", k, fu2Act[k], expFwd(ex_rs2, ex_rd2));
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    ex_rs1 = '0; ex_rs2 = '0; ex_rd1 = '0; ex_rd2 = '0;
    fwd_we = '0; fwd_wa = '0; fwd_data = '0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    id_valid = 1'b0; id_uses_rs2 = 1'b0; id_rs1 = '0; id_rs2 = '0;
    flush = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic setLoad(logic [RA_W-1:0] rd);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd; id_valid = 1'b1;
  endtask

  task automatic applyStimulus();
    reset       = ($urandom_range(0, 63) == 0);
    ex_rs1      = RA_W'($urandom_range(0, 7));
    ex_rs2      = RA_W'($urandom_range(0, 7));
    ex_rd1      = DATA_W'($urandom_range(0, 65535));
    ex_rd2      = DATA_W'($urandom_range(0, 65535));
    for (int i = 0; i < NSRC; i++) begin
      fwd_we[i]                    = ($urandom_range(0, 1) == 1);
      fwd_wa[i*RA_W +: RA_W]       = RA_W'($urandom_range(0, 7));
      fwd_data[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 65535));
    end
    ex_valid    = ($urandom_range(0, 3) != 0);
    ex_mem_read = ($urandom_range(0, 1) == 1);
    ex_rd       = RA_W'($urandom_range(0, 3));
    id_valid    = ($urandom_range(0, 3) != 0);
    id_uses_rs2 = ($urandom_range(0, 1) == 1);
    id_rs1      = RA_W'($urandom_range(0, 3));
    id_rs2      = RA_W'($urandom_range(0, 3));
    flush       = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    nextCycle();
    nextCycle();
    checkOutput("reset_stall", 1, stallAct[1], 0);
    checkOutput("reset_count", 1, cntAct[1], 0);
    reset = 1'b0;

    // Priority forwarding and fall-back.
    fwd_we = 2'b11; fwd_wa = {3'd3, 3'd3}; fwd_data = {16'h2222, 16'h1111};
    ex_rs1 = 3'd3; ex_rd1 = 16'hABCD;
    #1 checkOutput("fwd_youngest", 0, fu1Act[0], 16'h1111);
    fwd_we = 2'b10;
    #1 checkOutput("fwd_older", 0, fu1Act[0], 16'h2222);
    ex_rs1 = 3'd5;
    #1 checkOutput("fwd_fallback", 0, fu1Act[0], 16'hABCD);

    // Load-use on rs1, one-cycle latency.
    clearInputs(); doReset();
    setLoad(3'd2); id_rs1 = 3'd2; id_rs2 = 3'd7;
    #1 checkOutput("lat1_stall", 0, stallAct[0], 1);
    checkOutput("lat1_bubble", 0, bubbleAct[0], 1);
    nextCycle(); ex_valid = 1'b0;
    #1 checkOutput("lat1_release", 0, stallAct[0], 0);
    checkOutput("lat1_count", 0, cntAct[0], 1);

    // Second operand only matters when it is used.
    clearInputs(); doReset();
    setLoad(3'd4); id_rs1 = 3'd0; id_rs2 = 3'd4; id_uses_rs2 = 1'b0;
    #1 checkOutput("rs2_unused", 1, stallAct[1], 0);
    id_uses_rs2 = 1'b1;
    #1 checkOutput("rs2_used", 1, stallAct[1], 1);
    nextCycle(); ex_valid = 1'b0;
    #1 checkOutput("lat3_cyc1", 1, stallAct[1], 1);
    nextCycle();
    #1 checkOutput("lat3_cyc2", 1, stallAct[1], 1);
    nextCycle();
    #1 checkOutput("lat3_end", 1, stallAct[1], 0);
    checkOutput("lat3_count", 1, cntAct[1], 3);
    checkOutput("lat3_count_w2", 2, cntAct[2], 3);

    // Flush aborts a stall in progress.
    clearInputs(); doReset();
    setLoad(3'd2); id_rs1 = 3'd2;
    #1 checkOutput("flush_t0", 1, stallAct[1], 1);
    nextCycle(); ex_valid = 1'b0; flush = 1'b1;
    #1 checkOutput("flush_t1", 1, stallAct[1], 0);
    checkOutput("flush_bubble", 1, bubbleAct[1], 0);
    nextCycle(); flush = 1'b0;
    #1 checkOutput("flush_after", 1, stallAct[1], 0);
    checkOutput("flush_count", 1, cntAct[1], 1);

    // Asynchronous reset while holding.
    clearInputs(); doReset();
    setLoad(3'd1); id_rs1 = 3'd1;
    nextCycle(); ex_valid = 1'b0;
    #1 checkOutput("hold_stall", 1, stallAct[1], 1);
    reset = 1'b1;
    #1 checkOutput("async_rst_stall", 1, stallAct[1], 0);
    checkOutput("async_rst_count", 1, cntAct[1], 0);
    reset = 1'b0;
    #1 checkOutput("post_rst_stall", 1, stallAct[1], 0);

    // Back-to-back loads: five stall cycles saturate the 2-bit counter.
    clearInputs(); doReset();
    setLoad(3'd6); id_rs1 = 3'd6;
    nextCycle(); ex_valid = 1'b0;
    nextCycle();
    nextCycle();
    ex_valid = 1'b1;
    nextCycle(); ex_valid = 1'b0;
    nextCycle();
    checkOutput("sat_count16", 1, cntAct[1], 5);
    checkOutput("sat_count2", 2, cntAct[2], 3);
    checkOutput("lat1_two_loads", 0, cntAct[0], 2);

    clearInputs(); doReset();
    for (int n = 0; n < 3000; n++) begin
      nextCycle();
      applyStimulus();
    end
    nextCycle();
    reset = 1'b0;
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
